rect_painter: RTL

Pixel-colour stage directly downstream of the VGA 640x480 sync generator. It consumes the generator's HS, VS, X, Y and valid signals and draws one solid bordered rectangle over a background colour. The rectangle bounces around the visible area, and its position updates once per frame during vertical sync. The block outputs registered 8-bit RGB (3-3-2) plus HS/VS delayed to align with the pixel data at the DAC/pins.

---
 rtl/rect_painter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/rect_painter.sv
// -----------------------------------------------------------------------------
// rect_painter
//
// Pixel-colour stage that sits directly after a VGA 640x480 sync generator.
// It draws one solid, bordered rectangle over a background colour. The
// rectangle bounces around the visible area and moves once per frame. Each
// move happens on the frame tick, which falls in vertical blanking, so the
// picture never tears.
//
// Ports
//   VGA_CLK    in   pixel clock (25 MHz)
//   RST_N      in   asynchronous reset, active HIGH despite its name
//   HS_in      in   horizontal sync from the generator, active-low
//   VS_in      in   vertical sync from the generator, active-low
//   X, Y       in   visible column/row (0 outside the visible area)
//   valid      in   1 = X/Y address a visible pixel
//   move_en    in   1 = rectangle moves on each frame tick, 0 = frozen
//   VGA_HS     out  HS_in delayed two cycles (aligned with RGB)
//   VGA_VS     out  VS_in delayed two cycles (aligned with RGB)
//   RGB        out  registered RRRGGGBB colour, 0 when not visible
//   frame_tick out  one-cycle pulse after a falling edge of VS_in
//
// The pixel path has a latency of two cycles. A pixel presented in cycle n
// leaves on RGB in cycle n+2, together with the HS/VS of cycle n.
// -----------------------------------------------------------------------------
module rect_painter #(
    parameter int         SCREEN_W     = 640,
    parameter int         SCREEN_H     = 480,
    parameter int         RECT_W       = 64,
    parameter int         RECT_H       = 48,
    parameter int         STEP         = 2,
    parameter int         BORDER       = 2,
    parameter logic [7:0] RECT_COLOR   = 8'hE0,
    parameter logic [7:0] BORDER_COLOR = 8'hFF,
    parameter logic [7:0] BG_COLOR     = 8'h03
) (
    input  logic       VGA_CLK,
    input  logic       RST_N,
    input  logic       HS_in,
    input  logic       VS_in,
    input  logic [9:0] X,
    input  logic [9:0] Y,
    input  logic       valid,
    input  logic       move_en,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic [7:0] RGB,
    output logic       frame_tick
);

    typedef enum logic {
        DIR_FWD = 1'b0,   // right on X, down on Y
        DIR_REV = 1'b1    // left on X, up on Y
    } dir_t;

    logic       vs_prev_q, vs_prev_d;
    logic       frame_tick_q, frame_tick_d;
    logic       v1_q, v1_d;
    logic       in1_q, in1_d;
    logic       core1_q, core1_d;
    logic       hs1_q, hs1_d;
    logic       vs1_q, vs1_d;
    logic [7:0] rgb_q, rgb_d;
    logic       vga_hs_q, vga_hs_d;
    logic       vga_vs_q, vga_vs_d;

    // Per-axis hit tests: bit 0 = X axis, bit 1 = Y axis.
    logic [1:0] in_axis;
    logic [1:0] core_axis;

    logic move_tick;
    assign move_tick = frame_tick_q & move_en;

    // The two axes are identical apart from the coordinate, the rectangle
    // extent and the travel limit. Each axis carries its own position and
    // direction, so hitting a corner reverses both axes on the same tick.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            localparam int         LIM_I  = (gi == 0) ? (SCREEN_W - RECT_W) : (SCREEN_H - RECT_H);
            localparam int         SIZE_I = (gi == 0) ? RECT_W : RECT_H;
            localparam logic [10:0] LIM    = 11'(LIM_I);
            localparam logic [10:0] SIZE   = 11'(SIZE_I);
            localparam logic [10:0] STEP_W = 11'(STEP);
            localparam logic [10:0] BORD   = 11'(BORDER);

            logic [9:0]  pos_q, pos_d;
            dir_t        dir_q, dir_d;
            logic [10:0] pos_ext;
            logic [10:0] coord_ext;
            logic [10:0] step_sum;

            // All sums use 11 bits so that pos + extent cannot wrap.
            assign pos_ext   = {1'b0, pos_q};
            assign coord_ext = (gi == 0) ? {1'b0, X} : {1'b0, Y};
            assign step_sum  = pos_ext + STEP_W;

            always_comb begin
                pos_d = pos_q;
                dir_d = dir_q;
                if (move_tick) begin
                    if (dir_q == DIR_FWD) begin
                        // Clamp onto the far edge and bounce. The step never
                        // overshoots the visible area.
                        if (step_sum >= LIM) begin
                            pos_d = LIM[9:0];
                            dir_d = DIR_REV;
                        end else begin
                            pos_d = step_sum[9:0];
                        end
                    end else begin
                        if (pos_ext <= STEP_W) begin
                            pos_d = '0;
                            dir_d = DIR_FWD;
                        end else begin
                            pos_d = 10'(pos_ext - STEP_W);
                        end
                    end
                end
            end

            assign in_axis[gi]   = (coord_ext >= pos_ext) &&
                                   (coord_ext <  pos_ext + SIZE);
            // The interior is the rectangle shrunk by the border on both
            // sides. With BORDER = 0 it equals the rectangle, so no border
            // is drawn.
            assign core_axis[gi] = (coord_ext >= pos_ext + BORD) &&
                                   (coord_ext <  pos_ext + SIZE - BORD);

            always_ff @(posedge VGA_CLK or posedge RST_N) begin
                if (RST_N) begin
                    pos_q <= '0;
                    dir_q <= DIR_FWD;
                end else begin
                    pos_q <= pos_d;
                    dir_q <= dir_d;
                end
            end
        end
    endgenerate

    always_comb begin
        // Frame tick: falling edge of VS_in, registered.
        vs_prev_d    = VS_in;
        frame_tick_d = vs_prev_q & ~VS_in;

        // Stage 1: classify the pixel and carry the syncs along.
        v1_d    = valid;
        in1_d   = &in_axis;
        core1_d = &core_axis;
        hs1_d   = HS_in;
        vs1_d   = VS_in;

        // Stage 2: choose the colour.
        if (!v1_q) begin
            rgb_d = 8'h00;
        end else if (in1_q && !core1_q) begin
            rgb_d = BORDER_COLOR;
        end else if (in1_q) begin
            rgb_d = RECT_COLOR;
        end else begin
            rgb_d = BG_COLOR;
        end
        vga_hs_d = hs1_q;
        vga_vs_d = vs1_q;
    end

    // Sync stages reset to the inactive level (1). Everything else resets to 0.
    always_ff @(posedge VGA_CLK or posedge RST_N) begin
        if (RST_N) begin
            vs_prev_q    <= 1'b1;
            frame_tick_q <= 1'b0;
            v1_q         <= 1'b0;
            in1_q        <= 1'b0;
            core1_q      <= 1'b0;
            hs1_q        <= 1'b1;
            vs1_q        <= 1'b1;
            rgb_q        <= 8'h00;
            vga_hs_q     <= 1'b1;
            vga_vs_q     <= 1'b1;
        end else begin
            vs_prev_q    <= vs_prev_d;
            frame_tick_q <= frame_tick_d;
            v1_q         <= v1_d;
            in1_q        <= in1_d;
            core1_q      <= core1_d;
            hs1_q        <= hs1_d;
            vs1_q        <= vs1_d;
            rgb_q        <= rgb_d;
            vga_hs_q     <= vga_hs_d;
            vga_vs_q     <= vga_vs_d;
        end
    end

    assign RGB        = rgb_q;
    assign VGA_HS     = vga_hs_q;
    assign VGA_VS     = vga_vs_q;
    assign frame_tick = frame_tick_q;

endmodule
